jogador_automatico: RTL and testbench

JOGADOR_AUTOMATICO -- requirements
Module: jogador_automatico

---
 rtl/jogador_automatico.sv | 209 ++++++++++++++++++++
 tb/tb_jogador_automatico.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/jogador_automatico.sv
// jogador_automatico: automatic player for a memory-sequence game.
// It starts the game, records the one-hot LED steps the game shows, and
// once the LEDs stay quiet it presses the recorded steps back as button presses.
// Optional build macro: JOGADOR_ERRO_EN. When defined, the third replayed step
// (index 2) is pressed rotated left by one position, so the game's loss path
// can be exercised. The default build replays every step exactly.
//
// state     | code | meaning
// ----------+------+-----------------------------------------------------
// INICIAL   | 0    | idle, waiting for habilita
// INICIA    | 1    | one-cycle game start pulse, buffer cleared
// ESCUTA    | 2    | listening: capture LED steps, count quiet cycles
// PRESSIONA | 3    | holding the current replayed button
// SOLTA     | 4    | buttons released between presses
// FIM       | F    | game ended (pronto), wait for habilita to drop

module jogador_automatico #(
  parameter int PRESS_CYCLES = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int QUIET_CYCLES = 16,
  parameter int DEPTH        = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic [3:0] leds,
  input  logic       pronto,
  input  logic       ganhou,
  input  logic       perdeu,
  output logic [3:0] botoes,
  output logic       jogar,
  output logic       overflow,
  output logic [3:0] db_estado,
  output logic [4:0] db_tamanho
);

  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CMAX  = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
  localparam int CW    = $clog2(CMAX + 1);
  localparam int QW    = $clog2(QUIET_CYCLES + 1);

  typedef enum logic [3:0] {
    INICIAL   = 4'h0,
    INICIA    = 4'h1,
    ESCUTA    = 4'h2,
    PRESSIONA = 4'h3,
    SOLTA     = 4'h4,
    FIM       = 4'hF
  } estado_t;

  estado_t       state_q, state_d;
  logic [4:0]    tam_q, tam_d;
  logic [4:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [QW-1:0] quiet_q, quiet_d;
  logic          ovf_q, ovf_d;
  logic [3:0]    botoes_q, botoes_d;
  logic [3:0]    leds_prev_q;
  logic [3:0]    buf_q [DEPTH];

  logic          capture;
  logic          wr_en;
  logic [3:0]    entry_raw;
  logic [3:0]    entry;

  // Win/lose only distinguish the end of play; the debug code is F either way.
  logic          unused_resultado;
  assign unused_resultado = ganhou ^ perdeu;

  // Step captured only on a rising transition out of an all-zero LED sample.
  assign capture = (state_q == ESCUTA) && $onehot(leds) && (leds_prev_q == 4'd0);

  // Next-state, buffer bookkeeping and counters.
  always_comb begin
    state_d = state_q;
    tam_d   = tam_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    quiet_d = quiet_q;
    ovf_d   = ovf_q;
    wr_en   = 1'b0;

    case (state_q)
      INICIAL: begin
        if (habilita) state_d = INICIA;
      end

      INICIA: begin
        tam_d   = 5'd0;
        idx_d   = 5'd0;
        cnt_d   = '0;
        quiet_d = '0;
        ovf_d   = 1'b0;
        state_d = ESCUTA;
      end

      ESCUTA: begin
        if (capture) begin
          if (tam_q == 5'(DEPTH)) begin
            ovf_d = 1'b1;
          end else begin
            wr_en = 1'b1;
            tam_d = tam_q + 5'd1;
          end
        end
        if (leds != 4'd0) begin
          quiet_d = '0;
        end else if (tam_q != 5'd0) begin
          if (quiet_q == QW'(QUIET_CYCLES - 1)) begin
            quiet_d = '0;
            idx_d   = 5'd0;
            cnt_d   = CW'(PRESS_CYCLES - 1);
            state_d = PRESSIONA;
          end else begin
            quiet_d = quiet_q + QW'(1);
          end
        end
      end

      PRESSIONA: begin
        if (cnt_q == '0) begin
          cnt_d   = CW'(GAP_CYCLES - 1);
          state_d = SOLTA;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      SOLTA: begin
        if (cnt_q == '0) begin
          if (idx_q + 5'd1 == tam_q) begin
            tam_d   = 5'd0;
            idx_d   = 5'd0;
            state_d = ESCUTA;
          end else begin
            idx_d   = idx_q + 5'd1;
            cnt_d   = CW'(PRESS_CYCLES - 1);
            state_d = PRESSIONA;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      FIM: begin
        if (!habilita) state_d = INICIAL;
      end

      default: state_d = INICIAL;
    endcase

    // End of play wins over everything; dropping habilita aborts anything but FIM.
    if (state_q != INICIAL && pronto) begin
      state_d = FIM;
    end else if (state_q != FIM && !habilita) begin
      state_d = INICIAL;
    end
  end

  // Button value for the entry about to be held, optionally corrupted at index 2.
  always_comb begin
    entry_raw = buf_q[idx_d[IW-1:0]];
`ifdef JOGADOR_ERRO_EN
    if (idx_d == 5'd2 && tam_q >= 5'd3) begin
      entry = {entry_raw[2:0], entry_raw[3]};
    end else begin
      entry = entry_raw;
    end
`else
    entry = entry_raw;
`endif
    botoes_d = (state_d == PRESSIONA) ? entry : 4'd0;
  end

  // State, counters and registered button drive.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= INICIAL;
      tam_q       <= 5'd0;
      idx_q       <= 5'd0;
      cnt_q       <= '0;
      quiet_q     <= '0;
      ovf_q       <= 1'b0;
      botoes_q    <= 4'd0;
      leds_prev_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      tam_q       <= tam_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      quiet_q     <= quiet_d;
      ovf_q       <= ovf_d;
      botoes_q    <= botoes_d;
      leds_prev_q <= leds;
    end
  end

  // Sequence storage; contents beyond db_tamanho are never read, so no reset.
  always_ff @(posedge clock) begin
    if (wr_en) buf_q[tam_q[IW-1:0]] <= leds;
  end

  assign botoes     = botoes_q;
  assign jogar      = (state_q == INICIA);
  assign overflow   = ovf_q;
  assign db_estado  = state_q;
  assign db_tamanho = tam_q;

endmodule

// File: tb/tb_jogador_automatico.sv
// Directed bench for jogador_automatico: start pulse, capture rules,
// replay timing, overflow, end-of-play, enable drop and reset behaviour.
module tb_jogador_automatico;

  logic       clock = 1'b0;
  logic       reset;
  logic       habilita;
  logic [3:0] leds;
  logic       pronto, ganhou, perdeu;
  logic [3:0] botoes;
  logic       jogar, overflow;
  logic [3:0] db_estado;
  logic [4:0] db_tamanho;

  int n_checks = 0;
  int n_fail   = 0;

  jogador_automatico dut (
    .clock      (clock),
    .reset      (reset),
    .habilita   (habilita),
    .leds       (leds),
    .pronto     (pronto),
    .ganhou     (ganhou),
    .perdeu     (perdeu),
    .botoes     (botoes),
    .jogar      (jogar),
    .overflow   (overflow),
    .db_estado  (db_estado),
    .db_tamanho (db_tamanho)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [3:0] v);
    leds = v;
    step();
    leds = 4'd0;
    step();
  endtask

  logic [3:0] prev_b;
  logic [3:0] exp_b;
  int         presses;
  logic [3:0] seen [3];

  initial begin
    reset = 1'b1; habilita = 1'b0; leds = 4'd0;
    pronto = 1'b0; ganhou = 1'b0; perdeu = 1'b0;
    step(); step();
    check("rst_estado", db_estado, 4'h0);
    check("rst_botoes", botoes, 4'h0);
    check("rst_jogar", jogar, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_tam", db_tamanho, 5'd0);

    // Start pulse
    reset = 1'b0; habilita = 1'b1;
    step();
    check("inicia_jogar", jogar, 1'b1);
    check("inicia_estado", db_estado, 4'h1);
    step();
    check("escuta_jogar", jogar, 1'b0);
    check("escuta_estado", db_estado, 4'h2);

    // Two steps captured, then replayed after 16 quiet cycles
    leds = 4'b0001; step();
    check("cap1_tam", db_tamanho, 5'd1);
    leds = 4'd0; step();
    leds = 4'b0100; step();
    check("cap2_tam", db_tamanho, 5'd2);
    leds = 4'd0; step();
    repeat (14) step();
    check("quiet15_estado", db_estado, 4'h2);
    step();
    check("quiet16_estado", db_estado, 4'h3);
    for (int t = 0; t < 16; t++) begin
      exp_b = (t < 4) ? 4'b0001 : (t < 8) ? 4'b0000 : (t < 12) ? 4'b0100 : 4'b0000;
      check($sformatf("replay2_t%0d", t), botoes, exp_b);
      step();
    end
    check("replay2_end_estado", db_estado, 4'h2);
    check("replay2_end_tam", db_tamanho, 5'd0);

    // Held and non-one-hot values are not captured
    leds = 4'b0010;
    repeat (10) step();
    leds = 4'b0011; step();
    leds = 4'd0; step();
    check("held_tam", db_tamanho, 5'd1);

    // Restart through INICIAL to clear the buffer
    habilita = 1'b0; step();
    check("hab0_estado", db_estado, 4'h0);
    check("hab0_botoes", botoes, 4'h0);
    habilita = 1'b1; step(); step();
    check("restart_estado", db_estado, 4'h2);
    check("restart_tam", db_tamanho, 5'd0);

    // 17 pulses: 16 kept, one dropped with overflow
    for (int i = 0; i < 17; i++) begin
      exp_b = 4'b0001 << (i % 4);
      pulse(exp_b);
    end
    check("ovf_tam", db_tamanho, 5'd16);
    check("ovf_flag", overflow, 1'b1);
    repeat (14) step();
    step();
    check("ovf_replay_start", db_estado, 4'h3);
    prev_b = 4'd0; presses = 0;
    for (int t = 0; t < 128; t++) begin
      check($sformatf("ovf_onehot_t%0d", t), {31'd0, $onehot0(botoes)}, 32'd1);
      if (botoes != 4'd0 && prev_b == 4'd0) begin
        exp_b = 4'b0001 << (presses % 4);
        check($sformatf("ovf_press%0d", presses), botoes, exp_b);
        presses++;
      end
      prev_b = botoes;
      step();
    end
    check("ovf_presses", presses, 16);
    check("ovf_end_estado", db_estado, 4'h2);
    check("ovf_sticky", overflow, 1'b1);

    // pronto in the second PRESSIONA cycle
    pulse(4'b0001);
    repeat (14) step();
    step();
    check("pr_t0_estado", db_estado, 4'h3);
    step();
    check("pr_t1_botoes", botoes, 4'b0001);
    pronto = 1'b1; step();
    check("pr_botoes", botoes, 4'h0);
    check("pr_estado", db_estado, 4'hF);
    pronto = 1'b0; ganhou = 1'b1; step();
    check("fim_hold", db_estado, 4'hF);
    check("fim_botoes", botoes, 4'h0);
    check("fim_jogar", jogar, 1'b0);
    ganhou = 1'b0; perdeu = 1'b1; step();
    check("fim_perdeu", db_estado, 4'hF);
    habilita = 1'b0; perdeu = 1'b0; step();
    check("fim_exit", db_estado, 4'h0);

    // Reset in the middle of listening
    habilita = 1'b1; step(); step();
    leds = 4'b1000; step();
    check("midrst_tam_pre", db_tamanho, 5'd1);
    leds = 4'd0; reset = 1'b1; step();
    check("midrst_estado", db_estado, 4'h0);
    check("midrst_tam", db_tamanho, 5'd0);
    check("midrst_botoes", botoes, 4'h0);
    check("midrst_ovf", overflow, 1'b0);

    // Three-step replay; index 2 is corrupted only in the error build
    reset = 1'b0; step(); step();
    check("seq3_escuta", db_estado, 4'h2);
    pulse(4'b0001); pulse(4'b0010); pulse(4'b1000);
    check("seq3_tam", db_tamanho, 5'd3);
    repeat (14) step();
    step();
    prev_b = 4'd0; presses = 0;
    for (int t = 0; t < 24; t++) begin
      if (botoes != 4'd0 && prev_b == 4'd0 && presses < 3) begin
        seen[presses] = botoes;
        presses++;
      end
      prev_b = botoes;
      step();
    end
    check("seq3_presses", presses, 3);
    check("seq3_p0", seen[0], 4'b0001);
    check("seq3_p1", seen[1], 4'b0010);
`ifdef JOGADOR_ERRO_EN
    check("seq3_p2", seen[2], 4'b0001);
`else
    check("seq3_p2", seen[2], 4'b1000);
`endif
    check("seq3_end", db_estado, 4'h2);

    // habilita dropped mid-press
    pulse(4'b0100);
    repeat (14) step();
    step(); step();
    check("midpress_botoes", botoes, 4'b0100);
    habilita = 1'b0; step();
    check("midpress_estado", db_estado, 4'h0);
    check("midpress_b0", botoes, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
